// File: rtl/cpu_seq.sv
// cpu_seq: multi-phase instruction sequencer.
// States IDLE / RUN / HALTED. One instruction takes PHASES non-stalled
// clocks; wait_req freezes the current phase. The run/halt decision is made
// only on the edge that retires an instruction, so an instruction is never
// cut short. Reset is asynchronous and active-low.
// Optional feature: define CPU_SEQ_STEP_EN to enable single-stepping from
// IDLE on a rising edge of the step input. When it is undefined, step is
// accepted but ignored and no step-edge register is built.
module cpu_seq #(
  parameter int PHASES    = 4,   // clock phases per instruction, 2..8
  parameter int CNT_WIDTH = 32   // width of the retired-instruction counter
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 wait_req,
  input  logic                 halt,
  input  logic                 step,
  output logic [PHASES-1:0]    phase,
  output logic [2:0]           phase_idx,
  output logic                 last,
  output logic                 running,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] icount
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(PHASES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [CNT_WIDTH-1:0] icount_q, icount_d;
  logic                 retire;

`ifdef CPU_SEQ_STEP_EN
  // Registered copy of step for 0->1 detection, plus a flag marking that
  // the instruction in flight was started by a step and must end in IDLE.
  logic step_q;
  logic step_start;
  logic single_q, single_d;

  assign step_start = step & ~step_q;

  // Step edge register and single-step flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q   <= 1'b0;
      single_q <= 1'b0;
    end else begin
      step_q   <= step;
      single_q <= single_d;
    end
  end
`else
  // Step is part of the port list but has no function in this build.
  logic unused_step;
  assign unused_step = step;
`endif

  // An instruction retires on the last phase when the stall is not active.
  assign retire = (state_q == ST_RUN) && (idx_q == LAST_IDX) && !wait_req;

  // Main state, phase index and retired-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= 3'd0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      icount_q <= icount_d;
    end
  end

  // Next-state logic: halt beats run in IDLE and at retirement; a stall
  // holds everything, including the retirement decision.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    icount_d = icount_q;
`ifdef CPU_SEQ_STEP_EN
    single_d = single_q;
`endif
    case (state_q)
      ST_IDLE: begin
        idx_d = 3'd0;
        if (halt) begin
          state_d = ST_HALTED;
        end else if (run) begin
          state_d  = ST_RUN;
`ifdef CPU_SEQ_STEP_EN
          single_d = 1'b0;
        end else if (step_start) begin
          state_d  = ST_RUN;
          single_d = 1'b1;
`endif
        end
      end
      ST_RUN: begin
        if (!wait_req) begin
          if (retire) begin
            idx_d    = 3'd0;
            icount_d = icount_q + CNT_ONE;
            if (halt) begin
              state_d = ST_HALTED;
`ifdef CPU_SEQ_STEP_EN
            end else if (single_q) begin
              state_d  = ST_IDLE;
              single_d = 1'b0;
`endif
            end else if (!run) begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_HALTED: begin
        idx_d = 3'd0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Status outputs decode straight from the registers so that reset clears
  // them without waiting for a clock.
  assign running   = (state_q == ST_RUN);
  assign halted    = (state_q == ST_HALTED);
  assign phase_idx = running ? idx_q : 3'd0;
  assign last      = retire;
  assign icount    = icount_q;

  // One-hot phase decode, one bit per phase position.
  generate
    for (genvar gi = 0; gi < PHASES; gi++) begin : g_phase
      assign phase[gi] = running && (idx_q == 3'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: scoreboard bench for cpu_seq with PHASES=5, CNT_WIDTH=4.
// The stimulus process drives inputs on the falling edge, asks the reference
// model what the outputs must be right now, and queues that expectation; a
// separate monitor pops and compares shortly afterwards.
module tb_cpu_seq;

  localparam int P = 5;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         run = 1'b0;
  logic         wait_req = 1'b0;
  logic         halt = 1'b0;
  logic         step = 1'b0;
  logic [P-1:0] phase;
  logic [2:0]   phase_idx;
  logic         last;
  logic         running;
  logic         halted;
  logic [W-1:0] icount;

  cpu_seq #(.PHASES(P), .CNT_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .wait_req  (wait_req),
    .halt      (halt),
    .step      (step),
    .phase     (phase),
    .phase_idx (phase_idx),
    .last      (last),
    .running   (running),
    .halted    (halted),
    .icount    (icount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [P-1:0] phase;
    logic [2:0]   idx;
    logic         last;
    logic         running;
    logic         halted;
    logic [W-1:0] icount;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 0;

  // Reference model: mode 0 = idle, 1 = executing, 2 = halted.
  int mode = 0;
  int pos = 0;        // phases completed within the current instruction
  int retired = 0;    // instructions retired since reset, modulo 2^W
  bit single = 0;     // current instruction was started by a step
  bit step_prev = 0;

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input bit r, input bit w, input bit h, input bit s);
    bit step_edge;
    step_edge = s && !step_prev;
    step_prev = s;
    if (mode == 0) begin
      if (h) mode = 2;
      else if (r) begin mode = 1; pos = 0; single = 0; end
`ifdef CPU_SEQ_STEP_EN
      else if (step_edge) begin mode = 1; pos = 0; single = 1; end
`endif
    end else if (mode == 1 && !w) begin
      pos = pos + 1;
      if (pos == P) begin
        pos = 0;
        retired = (retired + 1) % (1 << W);
        if (h) mode = 2;
        else if (single) begin mode = 0; single = 0; end
        else if (!r) mode = 0;
      end
    end
  endtask

  // One clock of stimulus: drive, queue expected outputs, step the model.
  task automatic cycle(input bit rn, input bit r, input bit w, input bit h, input bit s);
    exp_t e;
    @(negedge clk);
    reset = rn; run = r; wait_req = w; halt = h; step = s;
    if (!rn) begin
      mode = 0; pos = 0; retired = 0; single = 0; step_prev = 0;
    end
    e.running = (mode == 1);
    e.halted  = (mode == 2);
    e.phase   = '0;
    if (e.running) e.phase[pos] = 1'b1;
    e.idx     = e.running ? 3'(pos) : 3'd0;
    e.last    = e.running && (pos == P - 1) && !w;
    e.icount  = W'(retired);
    exp_q.push_back(e);
    if (rn) model_edge(r, w, h, s);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("phase",     32'(phase),     32'(e.phase));
        chk("phase_idx", 32'(phase_idx), 32'(e.idx));
        chk("last",      32'(last),      32'(e.last));
        chk("running",   32'(running),   32'(e.running));
        chk("halted",    32'(halted),    32'(e.halted));
        chk("icount",    32'(icount),    32'(e.icount));
        $display("txn t=%0t phase=%b idx=%0d last=%b run=%b halt=%b icount=%0d",
                 $time, phase, phase_idx, last, running, halted, icount);
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    // Reset state.
    repeat (2) cycle(0, 0, 0, 0, 0);
    // Continuous run: 16 instructions wrap the 4-bit counter back to 0.
    repeat (16 * P + 3) cycle(1, 1, 0, 0, 0);
    // Halt held mid-instruction: finishes the instruction, then sticks.
    repeat (2 * P) cycle(1, 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) cycle(1, i[0], 0, 0, 1);
    // Stall on the final phase defers retirement.
    cycle(0, 0, 0, 0, 0);
    repeat (P) cycle(1, 1, 0, 0, 0);
    repeat (3) cycle(1, 1, 1, 0, 0);
    repeat (P + 2) cycle(1, 1, 0, 0, 0);
    // Reset between edges mid-instruction.
    repeat (2) cycle(1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    // Step pulses in IDLE and mid-instruction with run low.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1);
    repeat (P + 3) cycle(1, 0, 0, 0, 0);
    // Halt in IDLE.
    cycle(1, 0, 0, 1, 0);
    repeat (3) cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit rn, r, w, h, s;
      rn = (mode == 2) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 49) != 0);
      r  = ($urandom_range(0, 9) < 7);
      w  = ($urandom_range(0, 7) < 2);
      h  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 5) == 0);
      cycle(rn, r, w, h, s);
    end
    repeat (3) @(negedge clk);
    done = 1;
    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
